// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - 2-way set-associative, write-through / no-write-allocate cache with LRU replacement
// The CPU side is held by stall; the memory side moves one word per mem_ack beat.
module set_assoc_cache #(
  parameter int DATA_WIDTH  = 32,
  parameter int SET_WIDTH   = 3,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic                    WE,
  input  logic                    StSrcM,
  input  logic                    LdSrcM,
  input  logic [DATA_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   WD,
  output logic [DATA_WIDTH-1:0]   RD,
  output logic                    stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wd,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rd,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int SETS  = 1 << SET_WIDTH;
  localparam int WOB   = $clog2(BLOCK_WORDS);
  localparam int OFF   = WOB + 2;
  localparam int TAG_W = DATA_WIDTH - SET_WIDTH - OFF;
  localparam int BW    = (WOB > 0) ? WOB : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_REFILL, S_RESP} state_t;

  state_t state, next_state;

  logic [BW-1:0]         beat;
  logic                  victim;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wd;
  logic                  r_we;
  logic                  r_sb;
  logic                  r_lbu;

  logic [SETS-1:0]       valid [2];
  logic [SETS-1:0]       lru;
  logic [TAG_W-1:0]      tag_mem  [2][SETS];
  logic [DATA_WIDTH-1:0] data_mem [2][SETS][BLOCK_WORDS];

  logic [TAG_W-1:0]      a_tag, r_tag;
  logic [SET_WIDTH-1:0]  a_set, r_set;
  logic [BW-1:0]         a_off, r_off;
  logic                  hit0, hit1, hit_way;
  logic                  acc_hit, acc_miss;
  logic                  victim_sel;
  logic                  refill_ack;
  logic [DATA_WIDTH-1:0] hit_word, resp_word;
  logic [DATA_WIDTH-1:0] st_data;
  logic [NB-1:0]         st_strb;

  function automatic logic [DATA_WIDTH-1:0] load_sel(input logic [DATA_WIDTH-1:0] w,
                                                     input logic [1:0] lane,
                                                     input logic lbu);
    logic [7:0] b;
    b = w[{lane, 3'b000} +: 8];
    return lbu ? DATA_WIDTH'(b) : w;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_data(input logic [DATA_WIDTH-1:0] wd,
                                                       input logic sb);
    return sb ? {NB{wd[7:0]}} : wd;
  endfunction

  function automatic logic [NB-1:0] store_strb(input logic [1:0] lane, input logic sb);
    return sb ? (NB'(1) << lane) : {NB{1'b1}};
  endfunction

  assign a_tag = A[DATA_WIDTH-1:SET_WIDTH+OFF];
  assign a_set = A[SET_WIDTH+OFF-1:OFF];
  assign a_off = (BLOCK_WORDS > 1) ? BW'(A >> 2) : '0;
  assign r_tag = r_addr[DATA_WIDTH-1:SET_WIDTH+OFF];
  assign r_set = r_addr[SET_WIDTH+OFF-1:OFF];
  assign r_off = (BLOCK_WORDS > 1) ? BW'(r_addr >> 2) : '0;

  // Tags are unique per set because refills only happen on a miss, so at most one way matches.
  assign hit0     = valid[0][a_set] && (tag_mem[0][a_set] == a_tag);
  assign hit1     = valid[1][a_set] && (tag_mem[1][a_set] == a_tag);
  assign hit_way  = hit1;
  assign acc_hit  = (state == S_IDLE) && req && (hit0 || hit1);
  assign acc_miss = (state == S_IDLE) && req && !(hit0 || hit1);

  assign victim_sel = !valid[0][a_set] ? 1'b0 :
                      !valid[1][a_set] ? 1'b1 : lru[a_set];

  assign refill_ack = (state == S_REFILL) && mem_ack;
  assign hit_word   = data_mem[hit_way][a_set][a_off];
  assign resp_word  = data_mem[victim][r_set][r_off];
  assign st_data    = store_data(WD, StSrcM);
  assign st_strb    = store_strb(A[1:0], StSrcM);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    RD         = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wd     = '0;
    mem_wstrb  = '0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WE) begin
            stall      = 1'b1;
            next_state = S_WRITE;
          end else if (hit0 || hit1) begin
            RD = load_sel(hit_word, A[1:0], LdSrcM);
          end else begin
            stall      = 1'b1;
            next_state = S_REFILL;
          end
        end
      end
      S_WRITE: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {r_addr[DATA_WIDTH-1:2], 2'b00};
        mem_wd    = store_data(r_wd, r_sb);
        mem_wstrb = store_strb(r_addr[1:0], r_sb);
        if (mem_ack) next_state = S_RESP;
      end
      S_REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {r_addr[DATA_WIDTH-1:OFF], {OFF{1'b0}}} | (DATA_WIDTH'(beat) << 2);
        if (mem_ack && (beat == LAST_BEAT)) next_state = S_RESP;
      end
      S_RESP: begin
        if (!r_we) RD = load_sel(resp_word, r_addr[1:0], r_lbu);
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    // Outputs are forced quiet while reset is asserted, whatever state is still registered.
    if (!rst_n) begin
      stall   = 1'b0;
      RD      = '0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat       <= '0;
      victim     <= 1'b0;
      valid[0]   <= '0;
      valid[1]   <= '0;
      lru        <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      r_addr     <= '0;
      r_wd       <= '0;
      r_we       <= 1'b0;
      r_sb       <= 1'b0;
      r_lbu      <= 1'b0;
    end else begin
      if ((state == S_IDLE) && req) begin
        r_addr <= A;
        r_wd   <= WD;
        r_we   <= WE;
        r_sb   <= StSrcM;
        r_lbu  <= LdSrcM;
      end
      if (acc_hit) begin
        lru[a_set] <= ~hit_way;
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end
      if (acc_miss) begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
        if (!WE) begin
          victim <= victim_sel;
          beat   <= '0;
        end
      end
      if (refill_ack) begin
        beat <= beat + 1'b1;
        if (beat == LAST_BEAT) begin
          valid[victim][r_set] <= 1'b1;
          lru[r_set]           <= ~victim;
        end
      end
    end
  end

  // Tag and data storage carry no reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (acc_hit && WE) begin
      for (int i = 0; i < NB; i++) begin
        if (st_strb[i]) data_mem[hit_way][a_set][a_off][i*8 +: 8] <= st_data[i*8 +: 8];
      end
    end
    if (refill_ack) begin
      data_mem[victim][r_set][beat] <= mem_rd;
      if (beat == LAST_BEAT) tag_mem[victim][r_set] <= r_tag;
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// tb/tb_set_assoc_cache.sv - directed self-checking bench for set_assoc_cache with a word-addressed memory model
module tb_set_assoc_cache;

  logic        clk = 1'b0;
  logic        rst_n, req, WE, StSrcM, LdSrcM;
  logic [31:0] A, WD, RD;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wd;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rd = 32'h0;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  set_assoc_cache #(.DATA_WIDTH(32), .SET_WIDTH(3), .BLOCK_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .WE(WE), .StSrcM(StSrcM), .LdSrcM(LdSrcM),
    .A(A), .WD(WD), .RD(RD), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rd(mem_rd),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Memory model and ack responder
  logic [31:0] tb_mem [0:1023];
  logic [31:0] rd_log [0:63];
  logic        resp_ack = 1'b0;
  logic        spur_ack = 1'b0;
  int          ack_delay  = 0;
  int          n_rd_beats = 0;
  int          n_wr       = 0;
  int          n_unstable = 0;
  logic [31:0] last_wr_addr, last_wr_wd;
  logic [3:0]  last_wr_strb;

  assign mem_ack = resp_ack | spur_ack;

  initial begin
    int          wait_cnt;
    logic        pending;
    logic [31:0] p_addr, p_wd;
    logic [3:0]  p_strb;
    logic        p_we;
    wait_cnt = 0;
    pending  = 1'b0;
    forever begin
      @(negedge clk);
      resp_ack = 1'b0;
      if (mem_req) begin
        if (pending && (mem_addr !== p_addr || mem_we !== p_we || mem_wd !== p_wd || mem_wstrb !== p_strb))
          n_unstable++;
        p_addr = mem_addr; p_we = mem_we; p_wd = mem_wd; p_strb = mem_wstrb;
        if (wait_cnt >= ack_delay) begin
          resp_ack = 1'b1;
          wait_cnt = 0;
          pending  = 1'b0;
          if (mem_we) begin
            n_wr++;
            last_wr_addr = mem_addr; last_wr_wd = mem_wd; last_wr_strb = mem_wstrb;
            for (int i = 0; i < 4; i++)
              if (mem_wstrb[i]) tb_mem[mem_addr[11:2]][i*8 +: 8] = mem_wd[i*8 +: 8];
          end else begin
            rd_log[n_rd_beats % 64] = mem_addr;
            mem_rd = tb_mem[mem_addr[11:2]];
            n_rd_beats++;
          end
        end else begin
          wait_cnt++;
          pending = 1'b1;
        end
      end else begin
        wait_cnt = 0;
        pending  = 1'b0;
      end
    end
  end

  int n_rd_stall = 0;

  // One CPU access; cyc counts cycles spent with stall high before the response cycle.
  task automatic cpu_op(input logic we, input logic sb, input logic lbu, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output int cyc);
    @(negedge clk);
    req = 1'b1; WE = we; StSrcM = sb; LdSrcM = lbu; A = a; WD = wd;
    #1;
    cyc = 0;
    while (stall && cyc < 300) begin
      if (RD !== 32'h0) n_rd_stall++;
      @(negedge clk); #1;
      cyc++;
    end
    rd = RD;
    check("op_done", {31'b0, stall}, 32'h0);
    @(posedge clk); #1;
    req = 1'b0; WE = 1'b0; StSrcM = 1'b0; LdSrcM = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  logic [31:0] rd;
  int          cyc, nr0, nw0, guard;

  initial begin
    for (int i = 0; i < 1024; i++) tb_mem[i] = 32'hC000_0000 | (i << 2);
    tb_mem[32'h40] = 32'h11; tb_mem[32'h41] = 32'h22;
    tb_mem[32'h42] = 32'h33; tb_mem[32'h43] = 32'h44;

    // Reset with a pending request: outputs must stay quiet.
    rst_n = 1'b0; req = 1'b1; WE = 1'b0; StSrcM = 1'b0; LdSrcM = 1'b0; A = 32'h100; WD = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_rd", RD, 32'h0);
    check("rst_hits", hit_count, 32'h0);
    check("rst_misses", miss_count, 32'h0);
    @(negedge clk); rst_n = 1'b1; req = 1'b0;

    // Cold read, 4 beats, then a same-cycle hit on the same line
    nr0 = n_rd_beats;
    cpu_op(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, rd, cyc);
    check("cold_rd", rd, 32'h11);
    check("cold_cyc", 32'(cyc), 32'd5);
    check("cold_beats", 32'(n_rd_beats - nr0), 32'd4);
    for (int i = 0; i < 4; i++) check("cold_beat_addr", rd_log[(nr0 + i) % 64], 32'h100 + 32'(4 * i));
    check("cold_misses", miss_count, 32'd1);
    cpu_op(1'b0, 1'b0, 1'b0, 32'h108, 32'h0, rd, cyc);
    check("hit_rd", rd, 32'h33);
    check("hit_cyc", 32'(cyc), 32'd0);
    check("hit_count1", hit_count, 32'd1);

    // Byte store on the cached line, then byte and word loads
    nw0 = n_wr;
    cpu_op(1'b1, 1'b1, 1'b0, 32'h101, 32'hAB, rd, cyc);
    check("sb_cyc", 32'(cyc), 32'd2);
    check("sb_rd_zero", rd, 32'h0);
    check("sb_writes", 32'(n_wr - nw0), 32'd1);
    check("sb_addr", last_wr_addr, 32'h100);
    check("sb_wd", last_wr_wd, 32'hABABABAB);
    check("sb_strb", {28'b0, last_wr_strb}, 32'h2);
    check("sb_hits", hit_count, 32'd2);
    cpu_op(1'b0, 1'b0, 1'b1, 32'h101, 32'h0, rd, cyc);
    check("lbu_rd", rd, 32'h000000AB);
    check("lbu_cyc", 32'(cyc), 32'd0);
    cpu_op(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, rd, cyc);
    check("lw_merged", rd, 32'h0000AB11);
    check("hit_count4", hit_count, 32'd4);

    // Store miss: one write, no refill; the following load refills
    nw0 = n_wr; nr0 = n_rd_beats;
    cpu_op(1'b1, 1'b0, 1'b0, 32'h200, 32'hDEADBEEF, rd, cyc);
    check("swm_cyc", 32'(cyc), 32'd2);
    check("swm_writes", 32'(n_wr - nw0), 32'd1);
    check("swm_no_refill", 32'(n_rd_beats - nr0), 32'd0);
    check("swm_wd", last_wr_wd, 32'hDEADBEEF);
    check("swm_strb", {28'b0, last_wr_strb}, 32'hF);
    check("swm_misses", miss_count, 32'd2);
    cpu_op(1'b0, 1'b0, 1'b0, 32'h200, 32'h0, rd, cyc);
    check("lw200_cyc", 32'(cyc), 32'd5);
    check("lw200_rd", rd, 32'hDEADBEEF);
    check("lw200_misses", miss_count, 32'd3);

    // Reset during REFILL beat 2
    nr0 = n_rd_beats;
    @(negedge clk); req = 1'b1; WE = 1'b0; A = 32'h300; #1;
    guard = 0;
    while ((n_rd_beats - nr0) < 2 && guard < 50) begin @(negedge clk); #1; guard++; end
    check("mid_reach_beat2", 32'(n_rd_beats - nr0), 32'd2);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_mem_req", {31'b0, mem_req}, 32'h0);
    check("mid_stall", {31'b0, stall}, 32'h0);
    @(negedge clk); req = 1'b0; rst_n = 1'b1; #1;
    check("mid_hits", hit_count, 32'h0);
    check("mid_misses", miss_count, 32'h0);
    check("mid_idle_req", {31'b0, mem_req}, 32'h0);
    cpu_op(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, rd, cyc);
    check("post_rst_100_cyc", 32'(cyc), 32'd5);
    check("post_rst_100_rd", rd, 32'h0000AB11);
    cpu_op(1'b0, 1'b0, 1'b0, 32'h200, 32'h0, rd, cyc);
    check("post_rst_200_cyc", 32'(cyc), 32'd5);

    // Eviction in set 0
    do_reset();
    cpu_op(1'b0, 1'b0, 1'b0, 32'h000, 32'h0, rd, cyc);
    check("ev_000_rd", rd, 32'hC0000000);
    check("ev_000_cyc", 32'(cyc), 32'd5);
    cpu_op(1'b0, 1'b0, 1'b0, 32'h080, 32'h0, rd, cyc);
    check("ev_080_rd", rd, 32'hC0000080);
    cpu_op(1'b0, 1'b0, 1'b0, 32'h000, 32'h0, rd, cyc);
    check("ev_000_hit", 32'(cyc), 32'd0);
    cpu_op(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, rd, cyc);
    check("ev_100_miss", 32'(cyc), 32'd5);
    cpu_op(1'b0, 1'b0, 1'b0, 32'h000, 32'h0, rd, cyc);
    check("ev_000_kept", 32'(cyc), 32'd0);
    cpu_op(1'b0, 1'b0, 1'b0, 32'h080, 32'h0, rd, cyc);
    check("ev_080_evicted", 32'(cyc), 32'd5);
    cpu_op(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, rd, cyc);
    check("ev_100_evicted", 32'(cyc), 32'd5);
    check("ev_hits", hit_count, 32'd2);
    check("ev_misses", miss_count, 32'd5);

    // Stretched acks: 5 idle cycles before every beat
    ack_delay = 5;
    cpu_op(1'b0, 1'b0, 1'b0, 32'h040, 32'h0, rd, cyc);
    check("slow_rd_cyc", 32'(cyc), 32'd25);
    check("slow_rd", rd, 32'hC0000040);
    cpu_op(1'b1, 1'b0, 1'b0, 32'h044, 32'h01020304, rd, cyc);
    check("slow_sw_cyc", 32'(cyc), 32'd7);
    check("slow_mem_word", tb_mem[32'h11], 32'h01020304);
    check("slow_stable", 32'(n_unstable), 32'd0);
    ack_delay = 0;
    cpu_op(1'b0, 1'b0, 1'b0, 32'h044, 32'h0, rd, cyc);
    check("slow_hit_rd", rd, 32'h01020304);
    check("slow_hit_cyc", 32'(cyc), 32'd0);
    check("slow_hits", hit_count, 32'd4);
    check("slow_misses", miss_count, 32'd6);

    // Spurious ack while idle
    @(negedge clk); spur_ack = 1'b1; #1;
    check("spur_mem_req", {31'b0, mem_req}, 32'h0);
    check("spur_stall", {31'b0, stall}, 32'h0);
    @(negedge clk); spur_ack = 1'b0; #1;
    check("spur_stall_after", {31'b0, stall}, 32'h0);
    check("spur_hits", hit_count, 32'd4);
    check("spur_misses", miss_count, 32'd6);
    cpu_op(1'b0, 1'b0, 1'b0, 32'h040, 32'h0, rd, cyc);
    check("spur_then_hit", 32'(cyc), 32'd0);
    cpu_op(1'b0, 1'b0, 1'b0, 32'h0C0, 32'h0, rd, cyc);
    check("spur_then_miss_cyc", 32'(cyc), 32'd5);
    check("spur_then_miss_rd", rd, 32'hC00000C0);
    cpu_op(1'b0, 1'b0, 1'b1, 32'h0C3, 32'h0, rd, cyc);
    check("lbu_lane3", rd, 32'h000000C0);
    check("final_hits", hit_count, 32'd6);
    check("final_misses", miss_count, 32'd7);
    check("rd_zero_while_stalled", 32'(n_rd_stall), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
